// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//   uart_state_e        : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   BAUD_CNT_W          : width of the per-bit cycle counter
//   calc_clks_per_bit() : clock cycles per line bit (integer division)
//   calc_parity()       : parity bit of a byte, even or odd
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Per-bit counter width; clks_per_bit above 65535 is not supported.
    localparam int unsigned BAUD_CNT_W = 16;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                      input int unsigned baud);
        return clk_freq_hz / baud;
    endfunction

    // Even parity is the XOR of the byte; odd parity is its inverse.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8-bit UART transmitter, LSB first, optional parity, one stop bit.
//   clk      : system clock, all logic on the rising edge
//   reset    : asynchronous active-high reset, aborts any frame in progress
//   tx_start : request to send tx_data, ignored while tx_busy is high
//   tx_data  : byte to send, latched on the accepting edge
//   tx_line  : registered serial output, idle high
//   tx_busy  : high from the cycle after acceptance until the frame ends
//   tx_done  : one-cycle pulse during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq   = 50000000,
    parameter int unsigned baud_rate  = 9600,
    parameter bit          parity_en  = 1'b0,
    parameter bit          parity_odd = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned           CLKS_PER_BIT = calc_clks_per_bit(clk_freq, baud_rate);
    localparam logic [BAUD_CNT_W-1:0] BIT_LAST     = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    // With one cycle per bit, the first stop cycle is already the last one.
    localparam bit                    STOP_IS_ONE  = (BIT_LAST == {BAUD_CNT_W{1'b0}});

    uart_state_e           state_q;
    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;
    logic [2:0]            bit_idx_q;
    logic [2:0]            bit_idx_d;
    logic [7:0]            shift_q;
    logic                  tx_line_q;
    logic                  tx_busy_q;
    logic                  tx_done_q;
    logic                  bit_end_s;

    assign cnt_d     = cnt_q + {{(BAUD_CNT_W-1){1'b0}}, 1'b1};
    assign bit_idx_d = bit_idx_q + 3'd1;
    assign bit_end_s = (cnt_q == BIT_LAST);

    // Frame sequencer: state, baud counter, latched byte and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {BAUD_CNT_W{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_line_q <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= {BAUD_CNT_W{1'b0}};
                    bit_idx_q <= 3'd0;
                    if (tx_start) begin
                        // Start bit goes out in the very next cycle.
                        shift_q   <= tx_data;
                        state_q   <= ST_START;
                        tx_line_q <= 1'b0;
                        tx_busy_q <= 1'b1;
                    end else begin
                        tx_line_q <= 1'b1;
                        tx_busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_q     <= {BAUD_CNT_W{1'b0}};
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                        tx_line_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_q <= {BAUD_CNT_W{1'b0}};
                        if (bit_idx_q == 3'd7) begin
                            if (parity_en) begin
                                state_q   <= ST_PARITY;
                                tx_line_q <= calc_parity(shift_q, parity_odd);
                            end else begin
                                state_q   <= ST_STOP;
                                tx_line_q <= 1'b1;
                                tx_done_q <= STOP_IS_ONE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            tx_line_q <= shift_q[bit_idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_q     <= {BAUD_CNT_W{1'b0}};
                        state_q   <= ST_STOP;
                        tx_line_q <= 1'b1;
                        tx_done_q <= STOP_IS_ONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        // Frame complete: back to IDLE, busy drops with it.
                        cnt_q     <= {BAUD_CNT_W{1'b0}};
                        state_q   <= ST_IDLE;
                        tx_line_q <= 1'b1;
                        tx_busy_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_d;
                        // Raise done so it is visible during the last stop cycle.
                        tx_done_q <= (cnt_d == BIT_LAST);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= {BAUD_CNT_W{1'b0}};
                    bit_idx_q <= 3'd0;
                    tx_line_q <= 1'b1;
                    tx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_line = tx_line_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
